// File: rtl/inv_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : inv_add_round_key
//  Description : Decryption-side AES round-key applier. Holds every expanded
//                round key (written in forward order 0..NUM_ROUNDS) and XORs
//                a byte-serial state stream with those keys in reverse order
//                (NUM_ROUNDS..0), one BLOCK_BYTES block per round, using
//                valid/ready handshakes on both sides.
//  Options     : INV_ARK_KEYCHK_EN - per-round written-bitmap; a start is
//                rejected (err pulse) until every key byte has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_add_round_key #(
   parameter int DATA_W      = 8,
   parameter int BLOCK_BYTES = 16,
   parameter int NUM_ROUNDS  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_wr_en,
   input  logic [3:0]        key_wr_round,
   input  logic [3:0]        key_wr_byte,
   input  logic [DATA_W-1:0] key_wr_data,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [3:0]        round_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int NUM_KEYS = NUM_ROUNDS + 1;
   localparam int DEPTH    = NUM_KEYS * BLOCK_BYTES;
   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int BC_W     = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FIN    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [3:0]        round_idx_q, round_idx_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;

   // Key store is deliberately left out of reset so keys survive an abort.
   logic [DATA_W-1:0] key_mem_q [DEPTH];

   logic              key_we;
   logic [ADDR_W-1:0] key_waddr;
   logic [ADDR_W-1:0] key_raddr;
   logic              in_ready_c;
   logic              accept;
   logic              keys_ready;
   logic              start_rej;

   // Key write qualification: only while idle and only for in-range indices.
   always_comb begin
      key_we    = key_wr_en && (state_q == ST_IDLE)
                  && (32'(key_wr_round) <= NUM_ROUNDS)
                  && (32'(key_wr_byte) < BLOCK_BYTES);
      key_waddr = ADDR_W'(key_wr_round) * ADDR_W'(BLOCK_BYTES) + ADDR_W'(key_wr_byte);
   end

   // Key store write port.
   always_ff @(posedge clk) begin
      if (key_we) begin
         key_mem_q[key_waddr] <= key_wr_data;
      end
   end

`ifdef INV_ARK_KEYCHK_EN
   logic [BLOCK_BYTES-1:0] wmap_q [NUM_KEYS];
   logic [BLOCK_BYTES-1:0] wmap_d [NUM_KEYS];
   logic                   err_q, err_d;

   // Bitmap next value includes a write landing this cycle, so a start
   // coinciding with the final key write is accepted.
   always_comb begin
      for (int r = 0; r < NUM_KEYS; r++) begin
         wmap_d[r] = wmap_q[r];
      end
      if (key_we) begin
         wmap_d[key_wr_round][key_wr_byte] = 1'b1;
      end
      keys_ready = 1'b1;
      for (int r = 0; r < NUM_KEYS; r++) begin
         if (!(&wmap_d[r])) begin
            keys_ready = 1'b0;
         end
      end
      err_d = start_rej;
   end

   // Written-bitmap and reject pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_KEYS; r++) begin
            wmap_q[r] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_KEYS; r++) begin
            wmap_q[r] <= wmap_d[r];
         end
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign keys_ready = 1'b1;
   assign err        = 1'b0;
`endif

   // Control FSM next state, counters and output register next values.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      round_idx_d = round_idx_q;
      busy_d      = busy_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      start_rej   = 1'b0;

      // Single output register: a new byte may enter whenever the held one
      // leaves in the same cycle, so continuous flow has no bubbles.
      in_ready_c = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
      accept     = in_ready_c && in_valid;
      key_raddr  = ADDR_W'(round_idx_q) * ADDR_W'(BLOCK_BYTES) + ADDR_W'(byte_cnt_q);

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (keys_ready) begin
                  state_d     = ST_STREAM;
                  round_idx_d = 4'(NUM_ROUNDS);
                  byte_cnt_d  = '0;
                  busy_d      = 1'b1;
               end else begin
                  start_rej = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (accept) begin
               if (byte_cnt_q == BC_W'(BLOCK_BYTES - 1)) begin
                  byte_cnt_d = '0;
                  if (round_idx_q == 4'd0) begin
                     state_d = ST_DRAIN;
                  end else begin
                     round_idx_d = round_idx_q - 4'd1;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + BC_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Output data is only reloaded on an accept, so it holds under stall.
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ key_mem_q[key_raddr];
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Control and output registers; reset aborts any pass without done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= '0;
         round_idx_q <= 4'd0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         round_idx_q <= round_idx_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign in_ready  = in_ready_c;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign round_idx = round_idx_q;
   assign busy      = busy_q;
   assign done      = (state_q == ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_add_round_key
//  Description : Self-checking bench for inv_add_round_key with directed
//                vectors and hand-computed expected bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_add_round_key;

   localparam int NB = 176;

   logic       clk;
   logic       rst;
   logic       key_wr_en;
   logic [3:0] key_wr_round;
   logic [3:0] key_wr_byte;
   logic [7:0] key_wr_data;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] round_idx;
   logic       busy;
   logic       done;
   logic       err;

   int total;
   int bad;
   int done_cnt;

   typedef struct {
      int         idx;
      logic [7:0] din;
      logic [7:0] exp;
      logic [3:0] rnd;
   } vec_t;

   vec_t vecs [7];

   inv_add_round_key #(
      .DATA_W(8), .BLOCK_BYTES(16), .NUM_ROUNDS(10)
   ) dut (
      .clk(clk), .rst(rst),
      .key_wr_en(key_wr_en), .key_wr_round(key_wr_round),
      .key_wr_byte(key_wr_byte), .key_wr_data(key_wr_data),
      .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .round_idx(round_idx), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_key(input int r, input int b, input logic [7:0] d);
      key_wr_en    = 1'b1;
      key_wr_round = 4'(r);
      key_wr_byte  = 4'(b);
      key_wr_data  = d;
      tick();
      key_wr_en    = 1'b0;
   endtask

   // Key value convention for the bulk load: key[r][b] = r*16 + b.
   task automatic load_rounds(input int lo, input int hi);
      for (int r = lo; r <= hi; r++)
         for (int b = 0; b < 16; b++)
            wr_key(r, b, 8'(r * 16 + b));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [7:0] din_at(input int i);
      logic [7:0] d;
      d = 8'h00;
      for (int k = 0; k < 7; k++)
         if (vecs[k].idx == i) d = vecs[k].din;
      return d;
   endfunction

   // Accept i carries round 10 - i/16, byte i%16.
   function automatic logic [7:0] exp_at(input int i);
      logic [7:0] e;
      e = 8'((10 - i / 16) * 16 + (i % 16)) ^ din_at(i);
      for (int k = 0; k < 7; k++)
         if (vecs[k].idx == i) e = vecs[k].exp;
      return e;
   endfunction

   function automatic logic [3:0] rnd_at(input int i);
      return 4'(10 - i / 16);
   endfunction

   task automatic run_pass(input int first, input int last);
      int n;
      int done_before;
      done_before = done_cnt;
      out_ready = 1'b1;
      for (int i = first; i <= last; i++) begin
         in_valid = 1'b1;
         in_data  = din_at(i);
         #1;
         n = 0;
         while (in_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
         end
         if (in_ready !== 1'b1) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            break;
         end
         chk("round_idx", 32'(round_idx), 32'(rnd_at(i)));
         tick();
         chk("out_valid", 32'(out_valid), 32'd1);
         chk($sformatf("out_data[%0d]", i), 32'(out_data), 32'(exp_at(i)));
      end
      in_valid = 1'b0;
      if (last == NB - 1) begin
         chk("drain_done_low", 32'(done), 32'd0);
         chk("drain_in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("fin_done", 32'(done), 32'd1);
         tick();
         chk("idle_done_low", 32'(done), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("done_count", 32'(done_cnt - done_before), 32'd1);
      end
   endtask

   initial begin
      total = 0; bad = 0; done_cnt = 0;
      vecs[0] = '{idx:   0, din: 8'h00, exp: 8'hA0, rnd: 4'd10};
      vecs[1] = '{idx:   1, din: 8'hFF, exp: 8'h5E, rnd: 4'd10};
      vecs[2] = '{idx:  15, din: 8'h0F, exp: 8'hA0, rnd: 4'd10};
      vecs[3] = '{idx:  16, din: 8'h90, exp: 8'h00, rnd: 4'd9};
      vecs[4] = '{idx:  87, din: 8'h3C, exp: 8'h6B, rnd: 4'd5};
      vecs[5] = '{idx: 160, din: 8'hA5, exp: 8'hA5, rnd: 4'd0};
      vecs[6] = '{idx: 175, din: 8'hF0, exp: 8'hFF, rnd: 4'd0};

      rst = 1'b1; key_wr_en = 1'b0; key_wr_round = '0; key_wr_byte = '0;
      key_wr_data = '0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_round_idx", 32'(round_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // Partial key load then start
      load_rounds(0, 9);
      pulse_start();
`ifdef INV_ARK_KEYCHK_EN
      chk("partial_err", 32'(err), 32'd1);
      chk("partial_busy", 32'(busy), 32'd0);
      tick();
      chk("partial_err_pulse", 32'(err), 32'd0);
      chk("partial_busy2", 32'(busy), 32'd0);
`else
      chk("partial_err", 32'(err), 32'd0);
      chk("partial_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("partial_abort_busy", 32'(busy), 32'd0);
`endif

      // Full load and a complete pass with table vectors
      load_rounds(10, 10);
      pulse_start();
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_round", 32'(round_idx), 32'd10);
      chk("start_err", 32'(err), 32'd0);
      run_pass(0, NB - 1);

      // Back-pressure after the first accept
      pulse_start();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = din_at(0);
      #1;
      chk("bp_in_ready0", 32'(in_ready), 32'd1);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data0", 32'(out_data), 32'hA0);
      in_data = din_at(1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
         chk("bp_data_frozen", 32'(out_data), 32'hA0);
         chk("bp_valid_held", 32'(out_valid), 32'd1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      chk("bp_round", 32'(round_idx), 32'd10);
      tick();
      chk("bp_out_data1", 32'(out_data), 32'h5E);
      run_pass(2, NB - 1);

      // Reset after 20 accepts, then restart with retained keys
      pulse_start();
      run_pass(0, 19);
      begin
         int d0;
         d0 = done_cnt;
         rst = 1'b1;
         tick();
         rst = 1'b0;
         chk("abort_busy", 32'(busy), 32'd0);
         chk("abort_out_valid", 32'(out_valid), 32'd0);
         chk("abort_round", 32'(round_idx), 32'd0);
         chk("abort_out_data", 32'(out_data), 32'd0);
         chk("abort_in_ready", 32'(in_ready), 32'd0);
         chk("abort_done", 32'(done), 32'd0);
         tick();
         chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      end
`ifdef INV_ARK_KEYCHK_EN
      load_rounds(0, 10);
`endif
      pulse_start();
      chk("restart_round", 32'(round_idx), 32'd10);
      run_pass(0, NB - 1);

      // Single-byte key check, ignored write and start while busy
      wr_key(10, 0, 8'h9B);
      pulse_start();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hCB;
      #1;
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("t1_out_data", 32'(out_data), 32'h50);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_round", 32'(round_idx), 32'd10);
      in_valid     = 1'b0;
      key_wr_en    = 1'b1;
      key_wr_round = 4'd10;
      key_wr_byte  = 4'd0;
      key_wr_data  = 8'hFF;
      start        = 1'b1;
      tick();
      key_wr_en = 1'b0;
      start     = 1'b0;
      chk("busy_start_busy", 32'(busy), 32'd1);
      chk("busy_start_round", 32'(round_idx), 32'd10);
      chk("busy_start_err", 32'(err), 32'd0);
      chk("busy_out_valid_clr", 32'(out_valid), 32'd0);
      run_pass(1, NB - 1);

      pulse_start();
      in_valid = 1'b1;
      in_data  = 8'hCB;
      #1;
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("t5_out_data", 32'(out_data), 32'h50);
      run_pass(1, NB - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
